ad9833_driver: RTL and testbench



---
 rtl/ad9833_driver.sv | 154 +++++++++++++++
 tb/tb_ad9833_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ad9833_driver.sv
// ad9833_driver: serial master for the AD9833 DDS.
//   When a transfer is requested, it latches one control word and a 28-bit FREQ0
//   tuning word. It then shifts three 16-bit words to the chip, MSB first:
//   the control word, FREQ0[13:0] and FREQ0[27:14].
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   go                level request, sampled only while idle
//   control, freq     control word and FREQ0 tuning word
//   good_to_reset_go  1-cycle pulse when the request is accepted
//   send_complete     1-cycle pulse after all three words are sent
//   fsync, sclk       AD9833 frame sync and serial clock (both idle high)
//   sdata             AD9833 serial data (idle low)
// All outputs are registered. The comb block computes the next output levels,
// and the output flops load them on the same edge as the state register.
module ad9833_driver #(
    parameter int SCLK_HALF = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [15:0] control,
    input  logic [27:0] freq,
    output logic        good_to_reset_go,
    output logic        send_complete,
    output logic        fsync,
    output logic        sclk,
    output logic        sdata
);
    localparam int CW = $clog2(2 * SCLK_HALF);
    localparam logic [CW-1:0] HALF_END = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(2 * SCLK_HALF - 1);

    // S_DONE is the idle-level cycle that ends the last gap. S_CMPLT carries the
    // send_complete pulse. go is ignored in both states, so the earliest next
    // FSYNC fall is two cycles after the pulse.
    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE, S_CMPLT} state_t;

    state_t            state, state_n;
    logic [1:0]        word, word_n;
    logic [3:0]        bitn, bit_n;
    logic              low, low_n;     // 0: SCLK high phase, 1: SCLK low phase
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0][15:0]  wd, wd_n;
    logic              fsync_n, sclk_n, sdata_n, good_n, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            word             <= '0;
            bitn             <= '0;
            low              <= 1'b0;
            cnt              <= '0;
            wd               <= '0;
            fsync            <= 1'b1;
            sclk             <= 1'b1;
            sdata            <= 1'b0;
            good_to_reset_go <= 1'b0;
            send_complete    <= 1'b0;
        end else begin
            state            <= state_n;
            word             <= word_n;
            bitn             <= bit_n;
            low              <= low_n;
            cnt              <= cnt_n;
            wd               <= wd_n;
            fsync            <= fsync_n;
            sclk             <= sclk_n;
            sdata            <= sdata_n;
            good_to_reset_go <= good_n;
            send_complete    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        word_n  = word;
        bit_n   = bitn;
        low_n   = low;
        cnt_n   = cnt;
        wd_n    = wd;
        fsync_n = fsync;
        sclk_n  = sclk;
        sdata_n = sdata;
        good_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                fsync_n = 1'b1;
                sclk_n  = 1'b1;
                sdata_n = 1'b0;
                if (go) begin
                    wd_n[0] = control;
                    wd_n[1] = {2'b01, freq[13:0]};
                    wd_n[2] = {2'b01, freq[27:14]};
                    state_n = S_SHIFT;
                    word_n  = 2'd0;
                    bit_n   = 4'd15;
                    low_n   = 1'b0;
                    cnt_n   = '0;
                    fsync_n = 1'b0;
                    sdata_n = control[15];
                    good_n  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt != HALF_END) begin
                    cnt_n = cnt + CW'(1);
                end else begin
                    cnt_n = '0;
                    if (!low) begin
                        // Falling edge: the chip samples here, and sdata stays put.
                        low_n  = 1'b1;
                        sclk_n = 1'b0;
                    end else if (bitn != 4'd0) begin
                        low_n   = 1'b0;
                        bit_n   = bitn - 4'd1;
                        sclk_n  = 1'b1;
                        sdata_n = wd[word][bitn - 4'd1];
                    end else begin
                        // SCLK returns high on the same edge that FSYNC rises.
                        state_n = S_GAP;
                        low_n   = 1'b0;
                        fsync_n = 1'b1;
                        sclk_n  = 1'b1;
                        sdata_n = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (cnt != GAP_END) begin
                    cnt_n = cnt + CW'(1);
                end else begin
                    cnt_n = '0;
                    if (word == 2'd2) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_SHIFT;
                        word_n  = word + 2'd1;
                        bit_n   = 4'd15;
                        fsync_n = 1'b0;
                        sclk_n  = 1'b1;
                        sdata_n = wd[word + 2'd1][15];
                    end
                end
            end
            S_DONE: begin
                state_n = S_CMPLT;
                done_n  = 1'b1;
            end
            S_CMPLT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ad9833_driver.sv
// tb_ad9833_driver: directed and randomized bench for ad9833_driver.
//   A passive monitor samples on the falling clock edge and collects:
//   - the bits seen at each SCLK fall,
//   - the length of each FSYNC-low window,
//   - the cycles of the handshake pulses.
//   The main sequence compares these against words and timing computed
//   directly from the AD9833 framing rules.
module tb_ad9833_driver;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [15:0] control = '0;
    logic [27:0] freq = '0;
    logic        good_to_reset_go, send_complete, fsync, sclk, sdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit   bits_q[$];
    int   runs_q[$];
    int   good_q[$];
    int   sc_q[$];
    int   hold_err = 0;
    int   coinc_err = 0;
    int   run = 0;
    logic p_sclk = 1'b1, p_fsync = 1'b1, p_sdata = 1'b0;

    ad9833_driver #(.SCLK_HALF(H)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .control(control), .freq(freq),
        .good_to_reset_go(good_to_reset_go), .send_complete(send_complete),
        .fsync(fsync), .sclk(sclk), .sdata(sdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (p_sclk && !sclk) bits_q.push_back(sdata);
        if (!p_sclk && !sclk && sdata !== p_sdata) hold_err++;
        if (!fsync) run++;
        else if (run > 0) begin runs_q.push_back(run); run = 0; end
        if (good_to_reset_go) begin
            good_q.push_back(cyc);
            if (!(p_fsync && !fsync)) coinc_err++;
        end
        if (send_complete) sc_q.push_back(cyc);
        p_sclk = sclk; p_fsync = fsync; p_sdata = sdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // which: 0 = good_to_reset_go, 1 = send_complete. c = -1 on timeout.
    task automatic wait_sig(input int which, input int limit, input string tag, output int c);
        int n = 0;
        c = -1;
        while (n < limit) begin
            @(negedge clk); #1;
            n++;
            if ((which == 0 && good_to_reset_go) || (which == 1 && send_complete)) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++; errors++;
            $error("FAIL %s timeout observed=none expected=pulse", tag);
        end
    endtask

    function automatic logic [47:0] frame(input logic [15:0] c, input logic [27:0] f);
        return {c, 2'b01, f[13:0], 2'b01, f[27:14]};
    endfunction

    function automatic logic [47:0] stream_at(input int base);
        logic [47:0] s = '0;
        for (int i = 0; i < 48; i++)
            s = {s[46:0], (base + i < bits_q.size()) ? bits_q[base + i] : 1'b0};
        return s;
    endfunction

    task automatic check_stream(input string tag, input int bb, input int rb, input int gb,
                                input int sb, input logic [47:0] exp, input int gc, input int sc);
        logic [47:0] obs;
        int bad = 0;
        obs = stream_at(bb);
        chk({tag, " falls"}, bits_q.size() - bb, 48);
        chk({tag, " w0"}, obs[47:32], exp[47:32]);
        chk({tag, " w1"}, obs[31:16], exp[31:16]);
        chk({tag, " w2"}, obs[15:0], exp[15:0]);
        chk({tag, " fsync windows"}, runs_q.size() - rb, 3);
        for (int i = rb; i < runs_q.size(); i++) if (runs_q[i] != 32 * H) bad++;
        chk({tag, " window len"}, bad, 0);
        chk({tag, " good pulses"}, good_q.size() - gb, 1);
        chk({tag, " done pulses"}, sc_q.size() - sb, 1);
        chk({tag, " latency"}, sc - gc, 102 * H + 1);
        chk({tag, " good/fsync"}, coinc_err, 0);
        chk({tag, " sdata hold"}, hold_err, 0);
    endtask

    // chg_at > 0: write chg_val to freq that many cycles after acceptance.
    task automatic xfer(input string tag, input logic [15:0] c, input logic [27:0] f,
                        input int chg_at, input logic [27:0] chg_val);
        int bb, rb, gb, sb, gc, sc;
        control = c; freq = f;
        bb = bits_q.size(); rb = runs_q.size(); gb = good_q.size(); sb = sc_q.size();
        go = 1'b1;
        wait_sig(0, 20, {tag, " accept"}, gc);
        go = 1'b0;
        if (chg_at > 0) begin
            repeat (chg_at) @(negedge clk);
            #1 freq = chg_val;
        end
        wait_sig(1, 102 * H + 20, {tag, " complete"}, sc);
        repeat (2) @(negedge clk);
        #1;
        check_stream(tag, bb, rb, gb, sb, frame(c, f), gc, sc);
    endtask

    initial begin
        int gc, gc2, sc1, sc2, bb, gb, sb;
        logic [15:0] rc;
        logic [27:0] rf;

        // Reset held while the inputs wiggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            go = i[0]; control = 16'($urandom); freq = 28'($urandom);
            if (i >= 2) begin
                chk("rst fsync", fsync, 1'b1);
                chk("rst sclk", sclk, 1'b1);
                chk("rst sdata", sdata, 1'b0);
                chk("rst good", good_to_reset_go, 1'b0);
                chk("rst done", send_complete, 1'b0);
            end
        end
        go = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        xfer("basic", 16'hAAAD, 28'h0F00000, 0, '0);
        for (int k = 0; k < 3; k++) begin
            rc = 16'($urandom); rf = 28'($urandom);
            xfer("rand", rc, rf, 0, '0);
        end
        xfer("midchange", 16'h2100, 28'h0F00000, 34 * H + 5, 28'hFFFFFFF);

        // go held during a transfer is ignored; a second transfer follows 2 cycles after done.
        rc = 16'($urandom); rf = 28'($urandom);
        control = rc; freq = rf;
        bb = bits_q.size(); gb = good_q.size(); sb = sc_q.size();
        go = 1'b1;
        wait_sig(0, 20, "busy accept", gc);
        go = 1'b0;
        repeat (80) @(negedge clk);
        #1 go = 1'b1;
        wait_sig(1, 102 * H + 20, "busy done1", sc1);
        wait_sig(0, 10, "busy accept2", gc2);
        go = 1'b0;
        chk("busy restart gap", gc2 - sc1, 2);
        chk("busy good count", good_q.size() - gb, 2);
        wait_sig(1, 102 * H + 20, "busy done2", sc2);
        repeat (2) @(negedge clk);
        #1;
        chk("busy latency2", sc2 - gc2, 102 * H + 1);
        chk("busy done count", sc_q.size() - sb, 2);
        chk("busy frame1", stream_at(bb), frame(rc, rf));
        chk("busy frame2", stream_at(bb + 48), frame(rc, rf));

        // Reset mid-word: assert it at the start of word 1 bit 7.
        rc = 16'($urandom); rf = 28'($urandom);
        control = rc; freq = rf;
        sb = sc_q.size();
        go = 1'b1;
        wait_sig(0, 20, "rstmid accept", gc);
        go = 1'b0;
        repeat (50 * H) @(negedge clk);
        #1;
        chk("rstmid fsync low", fsync, 1'b0);
        chk("rstmid sdata bit7", sdata, rf[7]);
        rst_n = 1'b0;
        #1;
        chk("rstmid fsync", fsync, 1'b1);
        chk("rstmid sclk", sclk, 1'b1);
        chk("rstmid sdata", sdata, 1'b0);
        chk("rstmid good", good_to_reset_go, 1'b0);
        chk("rstmid done", send_complete, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rstmid no done", sc_q.size() - sb, 0);
        xfer("after rst", 16'($urandom), 28'($urandom), 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
